// File: rtl/accelerator_vector_calculus.sv
// accelerator_vector_calculus
//
// Streaming discrete differentiator / integrator over a vector of two's-complement
// samples with a power-of-two step.
//   MODE = 0 : y[0] = 0, y[i] = (x[i] - x[i-1]) >>> k
//   MODE = 1 : y[i] = y[i-1] + (x[i] <<< k), y[-1] = 0
// SATURATE selects clamping to the DATA_SIZE signed range (1) or wrap-around (0).
//
// Ports
//   CLK             clock, rising edge
//   RST             asynchronous active-low reset
//   START           one-cycle pulse, latches MODE / SIZE_IN / STEP_IN when idle
//   READY           one-cycle pulse when the vector is complete
//   MODE            0 = differentiation, 1 = integration
//   SIZE_IN         vector length (element count)
//   STEP_IN         step exponent k (step = 2^k)
//   DATA_IN_ENABLE  DATA_IN holds a valid element this cycle
//   DATA_IN         input element x[i]
//   DATA_ENABLE     high while elements are being accepted
//   DATA_OUT_ENABLE DATA_OUT valid this cycle
//   DATA_OUT        result element y[i], one cycle after its input
module accelerator_vector_calculus #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter bit          SATURATE     = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    MODE,
  input  logic [DATA_SIZE-1:0]    SIZE_IN,
  input  logic [CONTROL_SIZE-1:0] STEP_IN,
  input  logic                    DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic                    DATA_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  localparam logic signed [DATA_SIZE-1:0] MaxVal = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [DATA_SIZE-1:0] MinVal = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    StarterState,
    InputState,
    EnderState
  } state_e;

  state_e                  state_q, state_d;
  logic                    mode_q;
  logic [DATA_SIZE-1:0]    size_q;
  logic [CONTROL_SIZE-1:0] step_q;
  logic [DATA_SIZE-1:0]    index_q;
  logic [DATA_SIZE-1:0]    prev_q;
  logic [DATA_SIZE-1:0]    acc_q;
  logic                    data_out_en_q;
  logic [DATA_SIZE-1:0]    data_out_q;

  logic start_take;
  logic accept;
  logic last_elem;

  assign start_take = (state_q == StarterState) && START;
  assign accept     = (state_q == InputState) && DATA_IN_ENABLE;
  // size_q >= 1 whenever InputState is reachable, so size_q - 1 never underflows here.
  assign last_elem  = (index_q == size_q - DATA_SIZE'(1));

  // ---------------------------------------------------------------------------
  // Datapath: everything is evaluated one bit wider than DATA_SIZE so the
  // difference / sum are exact before the final clamp or truncation.
  // ---------------------------------------------------------------------------
  logic signed [DATA_SIZE-1:0] din_s;
  logic signed [DATA_SIZE-1:0] shl;
  logic signed [DATA_SIZE-1:0] shl_back;
  logic signed [DATA_SIZE-1:0] shl_eff;
  logic signed [DATA_SIZE:0]   x_wide;
  logic signed [DATA_SIZE:0]   prev_wide;
  logic signed [DATA_SIZE:0]   diff_wide;
  logic signed [DATA_SIZE:0]   sum_wide;
  logic signed [DATA_SIZE:0]   res_wide;
  logic        [DATA_SIZE-1:0] y;

  assign din_s     = $signed(DATA_IN);
  assign x_wide    = {DATA_IN[DATA_SIZE-1], DATA_IN};
  assign prev_wide = {prev_q[DATA_SIZE-1], prev_q};
  assign diff_wide = x_wide - prev_wide;
  assign shl       = din_s <<< step_q;
  // A left shift lost information iff shifting back does not recover the input;
  // this also covers k >= DATA_SIZE (result 0, recoverable only for x = 0).
  assign shl_back  = shl >>> step_q;

  always_comb begin
    shl_eff = shl;
    if (SATURATE && (shl_back != din_s)) begin
      shl_eff = din_s[DATA_SIZE-1] ? MinVal : MaxVal;
    end
  end

  assign sum_wide = {acc_q[DATA_SIZE-1], acc_q} + {shl_eff[DATA_SIZE-1], shl_eff};

  always_comb begin
    res_wide = '0;
    if (mode_q) begin
      res_wide = sum_wide;
    end else if (index_q != '0) begin
      res_wide = diff_wide >>> step_q;
    end
  end

  always_comb begin
    y = res_wide[DATA_SIZE-1:0];
    if (SATURATE && (res_wide[DATA_SIZE] != res_wide[DATA_SIZE-1])) begin
      y = res_wide[DATA_SIZE] ? MinVal : MaxVal;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StarterState: begin
        if (START) begin
          state_d = (SIZE_IN == '0) ? EnderState : InputState;
        end
      end
      InputState: begin
        if (accept && last_elem) begin
          state_d = EnderState;
        end
      end
      EnderState: state_d = StarterState;
      default:    state_d = StarterState;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StarterState;
      mode_q        <= 1'b0;
      size_q        <= '0;
      step_q        <= '0;
      index_q       <= '0;
      prev_q        <= '0;
      acc_q         <= '0;
      data_out_en_q <= 1'b0;
      data_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      data_out_en_q <= accept;
      if (start_take) begin
        mode_q  <= MODE;
        size_q  <= SIZE_IN;
        step_q  <= STEP_IN;
        index_q <= '0;
        prev_q  <= '0;
        acc_q   <= '0;
      end
      if (accept) begin
        index_q    <= index_q + DATA_SIZE'(1);
        prev_q     <= DATA_IN;
        acc_q      <= y;
        data_out_q <= y;
      end
    end
  end

  assign DATA_ENABLE     = (state_q == InputState);
  assign READY           = (state_q == EnderState);
  assign DATA_OUT_ENABLE = data_out_en_q;
  assign DATA_OUT        = data_out_q;

endmodule
